// File: rtl/popcount_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_sched_pkg
//  Description : Shared types, widths and helpers for the popcount stream
//                scheduler (state encoding, width derivation, saturating add).
//  Revision    : 1.0 - initial release
// ============================================================================
package popcount_sched_pkg;

    localparam int WORD_W = 64;   // requester word width
    localparam int PC_W   = 7;    // popcount of one word: 0..64
    localparam int SAT_W  = 32;   // working width of the saturating adder

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [SAT_W-1:0] sum;
    } sat_res_t;

    // Accumulator width able to hold MAX_WORDS full words without saturating
    function automatic int calc_cnt_w(input int max_words);
        return $clog2(max_words * WORD_W + 1);
    endfunction

    // Requester id width; never narrower than one bit
    function automatic int calc_id_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    // a + b clamped to 2^width-1; ovf flags that the clamp engaged
    function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                         input logic [SAT_W-1:0] b,
                                         input int               width);
        logic [SAT_W:0] s;
        logic [SAT_W:0] m;
        sat_res_t       r;
        s     = {1'b0, a} + {1'b0, b};
        m     = ({{SAT_W{1'b0}}, 1'b1} << width) - {{SAT_W{1'b0}}, 1'b1};
        r.ovf = (s > m);
        r.sum = r.ovf ? m[SAT_W-1:0] : s[SAT_W-1:0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_int64.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_int64
//  Description : Combinational population count of one 64-bit word.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_int64
    import popcount_sched_pkg::*;
(
    input  logic [WORD_W-1:0] i_data,
    output logic [PC_W-1:0]   o_count
);

    // Sum every bit of the word
    always_comb begin
        o_count = '0;
        for (int i = 0; i < WORD_W; i++) begin
            o_count = o_count + PC_W'(i_data[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/popcount_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_rr_arb
//  Description : Round-robin grant search. Picks the first asserted request at
//                or after the pointer, wrapping, and reports it as both a
//                one-hot vector and an index.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [ID_W-1:0]    o_gnt_idx,
    output logic               o_gnt_any
);

    // Scan from the pointer upward; the first hit wins
    always_comb begin
        int   k;
        logic found;
        k         = 0;
        found     = 1'b0;
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(i_ptr) + i) % NUM_REQ;
            if (!found && i_req[k]) begin
                found       = 1'b1;
                o_gnt_idx   = ID_W'(k);
                o_gnt_oh[k] = 1'b1;
            end
        end
        o_gnt_any = found;
    end

endmodule
`default_nettype wire

// File: rtl/popcount_stream_sched.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_stream_sched
//  Description : Shares one popcount_int64 datapath between NUM_REQ frame
//                streams. Frames are granted round-robin, per-word popcounts
//                are accumulated with saturation, and one tagged total is
//                returned per frame.
//  Build option: POPCOUNT_PIPE_EN - register the popcount before the
//                accumulator and insert a one-cycle DRAIN state.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_stream_sched
    import popcount_sched_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_WORDS = 16,
    localparam int ID_W      = calc_id_w(NUM_REQ),
    localparam int CNT_W     = calc_cnt_w(MAX_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [CNT_W-1:0]          rsp_count,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_sat,
    output logic                      busy
);

    state_t               r_state;
    state_t               w_next_state;

    logic [ID_W-1:0]      r_gnt;
    logic [NUM_REQ-1:0]   r_gnt_oh;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      w_ptr_next;
    logic [CNT_W-1:0]     r_acc;
    logic                 r_sat;

    logic [NUM_REQ-1:0]   w_arb_oh;
    logic [ID_W-1:0]      w_arb_idx;
    logic                 w_arb_any;

    logic [WORD_W-1:0]    w_word;
    logic [PC_W-1:0]      w_pc;
    logic                 w_beat;
    logic                 w_last_beat;

    logic                 w_add_en;
    logic [PC_W-1:0]      w_add_val;
    sat_res_t             w_sum;
    logic                 w_ovf;

    // ------------------------------------------------------------------
    // Grant selection and shared popcount datapath
    // ------------------------------------------------------------------
    popcount_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_arb_oh),
        .o_gnt_idx (w_arb_idx),
        .o_gnt_any (w_arb_any)
    );

    // The granted requester's lane is the only one that reaches the datapath
    assign w_word = req_data[int'(r_gnt)*WORD_W +: WORD_W];

    popcount_int64 u_pc (
        .i_data  (w_word),
        .o_count (w_pc)
    );

    // Only the granted requester can produce a beat; others are ignored
    assign w_beat      = (r_state == STREAM) && ((req_valid & r_gnt_oh) != '0);
    assign w_last_beat = w_beat && ((req_last & r_gnt_oh) != '0);

`ifdef POPCOUNT_PIPE_EN
    localparam logic c_pipe_en = 1'b1;

    logic [PC_W-1:0] r_pc;
    logic            r_pc_vld;

    // Popcount register: the accumulator sees each beat one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_pc_vld <= 1'b0;
        end else begin
            r_pc     <= w_pc;
            r_pc_vld <= w_beat;
        end
    end

    assign w_add_en  = r_pc_vld;
    assign w_add_val = r_pc;
`else
    localparam logic c_pipe_en = 1'b0;

    assign w_add_en  = w_beat;
    assign w_add_val = w_pc;
`endif

    // ------------------------------------------------------------------
    // Saturating accumulate
    // ------------------------------------------------------------------
    assign w_sum = sat_add(SAT_W'(r_acc), SAT_W'(w_add_val), CNT_W);

    // The clamped sum never exceeds CNT_W bits; folding the upper bits into
    // the flag keeps the full adder result consumed for any CNT_W.
    generate
        if (CNT_W < SAT_W) begin : g_fold_upper
            assign w_ovf = w_sum.ovf | (|w_sum.sum[SAT_W-1:CNT_W]);
        end else begin : g_no_fold
            assign w_ovf = w_sum.ovf;
        end
    endgenerate

    // Round-robin pointer moves just past the requester that was served
    assign w_ptr_next = (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + ID_W'(1);

    // ------------------------------------------------------------------
    // FSM: IDLE -> STREAM -> [DRAIN] -> RESP -> IDLE
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_arb_any)   w_next_state = STREAM;
            STREAM:  if (w_last_beat) w_next_state = c_pipe_en ? DRAIN : RESP;
            DRAIN:                    w_next_state = RESP;
            RESP:    if (rsp_ready)   w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // Output decode: ready only to the granted requester while streaming
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            STREAM:  req_ready = r_gnt_oh;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant and pointer registers
    // ------------------------------------------------------------------

    // Latch the grant in IDLE; advance the pointer on the response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt    <= '0;
            r_gnt_oh <= '0;
            r_ptr    <= '0;
        end else begin
            if ((r_state == IDLE) && w_arb_any) begin
                r_gnt    <= w_arb_idx;
                r_gnt_oh <= w_arb_oh;
            end
            if ((r_state == RESP) && rsp_ready) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // Accumulator: cleared at grant, sticky saturation flag per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if ((r_state == IDLE) && w_arb_any) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (w_add_en) begin
            r_acc <= w_sum.sum[CNT_W-1:0];
            r_sat <= r_sat | w_ovf;
        end
    end

    assign rsp_count = r_acc;
    assign rsp_id    = r_gnt;
    assign rsp_sat   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_popcount_stream_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount_stream_sched
//  Description : Self-checking bench for popcount_stream_sched. Requester
//                drivers consume per-lane beat queues; a response monitor
//                compares each handshake against the expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_stream_sched;

    localparam int NREQ  = 4;
    localparam int CNT_W = 11;             // MAX_WORDS = 16
    localparam int ID_W  = 2;
    localparam int CNT_S = 7;              // MAX_WORDS = 1
    localparam int CMAXI = (1 << CNT_W) - 1;
`ifdef POPCOUNT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_last  = '0;
    logic [NREQ*64-1:0] req_data  = '0;
    logic               rsp_rdy   = 1'b1;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [CNT_W-1:0]   rsp_count;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_sat;
    logic               busy;

    logic [NREQ-1:0]    s_valid = '0;
    logic [NREQ-1:0]    s_last  = '0;
    logic [NREQ*64-1:0] s_data  = '0;
    logic               s_rsp_rdy = 1'b1;
    logic [NREQ-1:0]    s_ready;
    logic               s_rsp_valid;
    logic [CNT_S-1:0]   s_rsp_count;
    logic [ID_W-1:0]    s_rsp_id;
    logic               s_rsp_sat;
    logic               s_busy;

    popcount_stream_sched #(.NUM_REQ(NREQ), .MAX_WORDS(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_count(rsp_count), .rsp_id(rsp_id),
        .rsp_sat(rsp_sat), .busy(busy)
    );

    popcount_stream_sched #(.NUM_REQ(NREQ), .MAX_WORDS(1)) dut_s (
        .clk(clk), .rst(rst),
        .req_valid(s_valid), .req_ready(s_ready), .req_data(s_data), .req_last(s_last),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_rdy), .rsp_count(s_rsp_count), .rsp_id(s_rsp_id),
        .rsp_sat(s_rsp_sat), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] d;
        logic        last;
        logic [7:0]  gap;
    } beat_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [ID_W-1:0]  id;
        logic             sat;
    } exp_t;

    beat_t       bq [NREQ][$];
    exp_t        exp_q[$];
    logic [63:0] fw[$];
    int          fg[$];

    bit pend     [NREQ];
    bit armed    [NREQ];
    bit stalling [NREQ];
    int stall    [NREQ];
    int beats_issued [NREQ];
    int last_beat_cyc = 0;
    int rsp_rise_cyc  = 0;
    bit rsp_valid_d   = 1'b0;

    // Move the staged frame (fw/fg) onto lane r and record its expected result
    task automatic push_frame(input int r);
        int    total;
        exp_t  e;
        beat_t b;
        total = 0;
        for (int i = 0; i < fw.size(); i++) begin
            b.d    = fw[i];
            b.last = (i == fw.size() - 1);
            b.gap  = 8'(fg[i]);
            bq[r].push_back(b);
            total += $countones(fw[i]);
        end
        e.sat = (total > CMAXI);
        e.cnt = e.sat ? CNT_W'(CMAXI) : CNT_W'(total);
        e.id  = ID_W'(r);
        exp_q.push_back(e);
        fw.delete();
        fg.delete();
    endtask

    // Requester drivers: present queued words, honour gaps, retire accepted beats
    always @(negedge clk) begin
        #2;
        for (int r = 0; r < NREQ; r++) begin
            if (pend[r]) begin
                if (bq[r].size() > 0) void'(bq[r].pop_front());
                armed[r] = 1'b0;
                pend[r]  = 1'b0;
            end
            if (bq[r].size() > 0) begin
                if (!armed[r]) begin
                    stall[r] = int'(bq[r][0].gap);
                    armed[r] = 1'b1;
                end
                if (stall[r] > 0) begin
                    stall[r]     = stall[r] - 1;
                    req_valid[r] = 1'b0;
                    stalling[r]  = 1'b1;
                end else begin
                    req_valid[r]        = 1'b1;
                    req_data[r*64 +: 64] = bq[r][0].d;
                    req_last[r]         = bq[r][0].last;
                    stalling[r]         = 1'b0;
                end
            end else begin
                req_valid[r] = 1'b0;
                req_last[r]  = 1'b0;
                stalling[r]  = 1'b0;
                armed[r]     = 1'b0;
            end
            if (req_valid[r] && req_ready[r] && !rst) begin
                pend[r] = 1'b1;
                beats_issued[r] = beats_issued[r] + 1;
                if (req_last[r]) last_beat_cyc = cyc;
            end
        end
    end

    // Response monitor: scoreboard compare on every handshake
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rsp_valid && !rsp_valid_d) rsp_rise_cyc = cyc;
        rsp_valid_d = rsp_valid;
        if (rsp_valid && rsp_rdy && !rst) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got count=%0d id=%0d sat=%0d, required no response",
                         rsp_count, rsp_id, rsp_sat);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_count, rsp_id, rsp_sat} !== {e.cnt, e.id, e.sat}) begin
                    n_fail++;
                    $display("FAIL sb_rsp: got count=%0d id=%0d sat=%0d, required count=%0d id=%0d sat=%0d",
                             rsp_count, rsp_id, rsp_sat, e.cnt, e.id, e.sat);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        n_checks++; if (req_ready !== '0)  begin n_fail++; $display("FAIL rst_ready: got %b, required 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
        n_checks++; if (rsp_count !== '0)  begin n_fail++; $display("FAIL rst_count: got %0d, required 0", rsp_count); end
        n_checks++; if (rsp_id !== '0)     begin n_fail++; $display("FAIL rst_id: got %0d, required 0", rsp_id); end
        n_checks++; if (rsp_sat !== 1'b0)  begin n_fail++; $display("FAIL rst_sat: got %b, required 0", rsp_sat); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_checks++; if ({s_ready, s_rsp_valid, s_busy} !== '0) begin
            n_fail++; $display("FAIL rst_sat_dut: got ready=%b valid=%b busy=%b, required all 0", s_ready, s_rsp_valid, s_busy);
        end
        @(negedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_single();
        int guard;
        fw.push_back(64'hFFFF_FFFF_FFFF_FFFF); fg.push_back(0);
        push_frame(0);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin @(negedge clk); #3; guard++; end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: got %0d outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (rsp_rise_cyc - last_beat_cyc !== LAT) begin
            n_fail++; $display("FAIL single_latency: got %0d cycles, required %0d", rsp_rise_cyc - last_beat_cyc, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        int viol;
        @(negedge clk); #1; rst = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            fw.push_back({$urandom, $urandom}); fg.push_back(0);
            fw.push_back({$urandom, $urandom}); fg.push_back(0);
            push_frame(r);
        end
        fw.push_back({$urandom, $urandom}); fg.push_back(0);
        fw.push_back({$urandom, $urandom}); fg.push_back(0);
        push_frame(0);
        guard = 0; viol = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk); #3; guard++;
            if ($countones(req_ready) > 1) viol++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: got %0d outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL rr_onehot: got %0d multi-ready cycles, required 0", viol); end
    endtask

    task automatic test_stall();
        int guard;
        int viol;
        int seen;
        fw.push_back(64'h1); fg.push_back(0);
        fw.push_back(64'h3); fg.push_back(3);
        fw.push_back(64'h7); fg.push_back(0);
        push_frame(2);
        guard = 0; viol = 0; seen = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk); #3; guard++;
            if (stalling[2]) begin
                seen++;
                if (req_ready[2] !== 1'b1) viol++;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_drain: got %0d outstanding, required 0", exp_q.size()); end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL stall_ready_held: got %0d cycles without ready, required 0", viol); end
        n_checks++;
        if (seen != 3) begin n_fail++; $display("FAIL stall_gap_len: got %0d gap cycles, required 3", seen); end
    endtask

    task automatic test_backpressure();
        int               guard;
        int               viol;
        logic [CNT_W-1:0] cnt0;
        logic [ID_W-1:0]  id0;
        @(negedge clk); #1; rsp_rdy = 1'b0;
        fw.push_back({$urandom, $urandom}); fg.push_back(0);
        push_frame(1);
        guard = 0;
        while (!rsp_valid && guard < 50) begin @(negedge clk); #3; guard++; end
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid: got %b, required 1", rsp_valid); end
        n_checks++;
        if (rsp_id !== ID_W'(1)) begin n_fail++; $display("FAIL bp_first_id: got %0d, required 1", rsp_id); end
        cnt0 = rsp_count;
        id0  = rsp_id;
        fw.push_back({$urandom, $urandom}); fg.push_back(0);
        push_frame(2);
        fw.push_back({$urandom, $urandom}); fg.push_back(0);
        push_frame(1);
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #3;
            if (rsp_valid !== 1'b1 || rsp_count !== cnt0 || rsp_id !== id0) viol++;
            if (req_ready !== '0 || busy !== 1'b1) viol++;
        end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles, required 0", viol); end
        @(negedge clk); #1; rsp_rdy = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin @(negedge clk); #3; guard++; end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_rst_midframe();
        int          guard;
        int          base;
        logic [63:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom} | 64'hFF00;
        for (int i = 0; i < 4; i++) begin fw.push_back(w[i]); fg.push_back(0); end
        push_frame(3);
        base  = beats_issued[3];
        guard = 0;
        while (beats_issued[3] < base + 2 && guard < 50) begin @(negedge clk); #1; guard++; end
        rst = 1'b1;
        bq[3].delete();
        armed[3] = 1'b0;
        stall[3] = 0;
        void'(exp_q.pop_back());
        @(negedge clk); #3;
        n_checks++;
        if ({req_ready, rsp_valid, busy, rsp_sat} !== '0 || rsp_count !== '0 || rsp_id !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got ready=%b valid=%b busy=%b count=%0d id=%0d sat=%b, required all 0",
                     req_ready, rsp_valid, busy, rsp_count, rsp_id, rsp_sat);
        end
        @(negedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin fw.push_back(w[i]); fg.push_back(0); end
        push_frame(3);
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin @(negedge clk); #3; guard++; end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_drain: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_saturate();
        int guard;
        @(negedge clk); #1;
        s_valid = 4'b0001;
        s_data[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int b = 0; b < 3; b++) begin
            s_last = (b == 2) ? 4'b0001 : 4'b0000;
            guard = 0;
            while (s_ready[0] !== 1'b1 && guard < 20) begin @(negedge clk); #1; guard++; end
            @(negedge clk); #1;
        end
        s_valid = '0;
        s_last  = '0;
        #2;
        guard = 0;
        while (!s_rsp_valid && guard < 10) begin @(negedge clk); #3; guard++; end
        n_checks++;
        if (s_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b, required 1", s_rsp_valid); end
        n_checks++;
        if (s_rsp_count !== CNT_S'(127)) begin n_fail++; $display("FAIL sat_count: got %0d, required 127", s_rsp_count); end
        n_checks++;
        if (s_rsp_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b, required 1", s_rsp_sat); end
        n_checks++;
        if (s_rsp_id !== '0) begin n_fail++; $display("FAIL sat_id: got %0d, required 0", s_rsp_id); end
        @(negedge clk); #3;
    endtask

    initial begin
        for (int r = 0; r < NREQ; r++) begin
            pend[r] = 1'b0; armed[r] = 1'b0; stalling[r] = 1'b0; stall[r] = 0; beats_issued[r] = 0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_backpressure();
        test_rst_midframe();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
